dmem_resp: RTL and testbench
============================

# dmem_resp

Data-memory responder for the core's data bus. It sits on the far end of `d_addr`/`d_rd_req`/`d_wr_req`, serves loads and stores from an internal byte-lane-writable word RAM, and inserts a programmable number of wait states. It drives `d_rd_ready`/`d_wr_ready` to end each core stall. Out-of-range accesses are reported through a sticky error flag.

## Interface
Parameters:
- `DEPTH_LOG2`, default 10: RAM holds 2^DEPTH_LOG2 32-bit words.
- `BASE_ADDR`, default 32'h0001_0000: byte address of word 0. Must be aligned to 4·2^DEPTH_LOG2.
- `WAIT_CYCLES`, default 0: extra cycles between request acceptance and the ready pulse. Range 0..15.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock
- `rstb`  in  1  async active-low reset
- `d_addr`  in  32  byte address; held stable by the core while a request is pending
- `d_rd_req`  in  1  load request; level, held until ready is seen
- `d_rd_ready`  out  1  one-cycle pulse; `d_rd_data` is valid in this cycle
- `d_rd_data`  out  32  full aligned word; the core does lane extraction
- `d_wr_req`  in  1  store request; level, held until ready is seen
- `d_wr_ready`  out  1  one-cycle pulse; the write commits at the end of this cycle
- `d_be`  in  4  byte enables for stores
- `d_wr_data`  in  32  store data, already lane-positioned
- `err_oob`  out  1  sticky; set on any out-of-range access, cleared only by reset

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE**
  - If `d_wr_req` is high: latch kind=WR, latch the word index and the range result. Go to WAIT if WAIT_CYCLES>0, else go to RESP.
  - Else if `d_rd_req` is high: latch kind=RD and do the same.
  - Write has priority when both requests are high. The read remains pending and is accepted in the IDLE cycle after the write's RESP.
- **WAIT**
  - The counter loads WAIT_CYCLES−1 on entry and decrements each cycle.
  - At 0, go to RESP.
- **RESP**
  - Assert the ready matching kind for exactly one cycle, then return to IDLE unconditionally.
- **Read data**
  - `d_rd_data` is registered on the edge entering RESP.
  - In range: RAM[index]. Out of range: 32'h0.
  - Holds its value outside RESP.
- **Write commit**
  - On the edge leaving RESP with kind=WR and in range, write each byte lane i where `d_be[i]`=1.
  - Data, `d_be` and `d_addr` are sampled at that edge.
  - Out-of-range writes are dropped.
- **Range**
  - In range when `d_addr[31:DEPTH_LOG2+2]` == `BASE_ADDR[31:DEPTH_LOG2+2]`.
  - Word index = `d_addr[DEPTH_LOG2+1:2]`; `d_addr[1:0]` is ignored.
- **err_oob** is set on the edge accepting an out-of-range request.
- **Back-to-back requests:** a request still high in the IDLE cycle after RESP is treated as a new transaction. The core does this for consecutive stores.
- **Request dropped early:** if a req deasserts before ready (not legal for the core), the transaction still completes. The ready pulse is issued anyway, and a write still commits using the current bus values.

## Timing
- Reset values:
  - state=IDLE, `d_rd_ready`=0, `d_wr_ready`=0, `d_rd_data`=0, `err_oob`=0, counter=0.
  - RAM contents are not reset.
- Latency: request first high in cycle 0 (IDLE) → ready high in cycle 1+WAIT_CYCLES.
- Occupancy: one transaction per 2+WAIT_CYCLES cycles.
- Ready outputs are registered and are never high in two consecutive cycles.
- `d_rd_ready` and `d_wr_ready` are never high together.
- Read-after-write to the same word in the next transaction returns the new data, because the commit precedes the next read capture.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and no ready is issued. A pending write is not committed unless its commit edge has already occurred.

## Structure
- Package `dmem_pkg` contains:
  - state enum `dmem_state_t` {IDLE, WAIT, RESP}
  - kind enum `dmem_kind_t` {RD, WR}
  - constant `DMEM_MAX_WAIT`=15
- Sub-module `dmem_ram`:
  - 2^DEPTH_LOG2 × 32 storage with a synchronous read port and a 4-lane byte-enabled synchronous write port.
  - No reset; maps to block RAM.
- `dmem_resp` holds the FSM, wait counter, latched index/kind/range, and the error flag.

## Test plan
- **Load latency:** WAIT_CYCLES=0, preload RAM[4]=32'hDEADBEEF; load at 32'h0001_0010 → `d_rd_ready` high in cycle 1 with `d_rd_data`=32'hDEADBEEF.
- **Wait states and byte enables:** WAIT_CYCLES=3; store 32'h00AB_0000 with `d_be`=4'h4 to 32'h0001_0012 over RAM[4]=32'h11223344 → `d_wr_ready` in cycle 4; a subsequent load returns 32'h11AB3344.
- **Back-to-back stores:** `d_wr_req` held high across two transactions (different addresses) → two `d_wr_ready` pulses separated by exactly one low cycle; both words written.
- **Out of range:** load at 32'h0000_0100 → `d_rd_ready` pulse, `d_rd_data`=0, `err_oob`=1 and staying 1. A store at 32'h0002_0000 → ready pulse, RAM unchanged.
- **Simultaneous requests:** `d_rd_req` and `d_wr_req` both high → write served first, read served in the following transaction and returns the just-written data.
- **Reset mid-transaction:** assert `rstb` low during WAIT of a store → no ready; after release, all outputs are 0 and the target word is unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

   typedef enum logic {RD, WR} dmem_kind_t;

   localparam int unsigned DMEM_MAX_WAIT = 15;

endpackage

// File: rtl/dmem_ram.sv
// Word RAM with a synchronous read port and a byte-lane-enabled synchronous write port.
module dmem_ram #(
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic                  clk_i,
   input  logic                  re_i,
   input  logic [DEPTH_LOG2-1:0] raddr_i,
   output logic [31:0]           rdata_o,
   input  logic                  we_i,
   input  logic [DEPTH_LOG2-1:0] waddr_i,
   input  logic [3:0]            be_i,
   input  logic [31:0]           wdata_i
);

   logic [31:0] mem_q [2**DEPTH_LOG2];
   logic [31:0] rdata_q;

   // No reset so the array maps onto block RAM.
   always_ff @(posedge clk_i) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
      if (we_i) begin
         for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
               mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// Data-bus responder: accepts one load or store at a time, inserts wait states,
// pulses the matching ready and flags out-of-range accesses.
module dmem_resp
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2  = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic [31:0] d_addr,
   input  logic        d_rd_req,
   output logic        d_rd_ready,
   output logic [31:0] d_rd_data,
   input  logic        d_wr_req,
   output logic        d_wr_ready,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_wr_data,
   output logic        err_oob
);

   localparam int unsigned TagLsb = DEPTH_LOG2 + 2;

   localparam logic [3:0] WaitInit =
      (WAIT_CYCLES == 0)             ? 4'd0 :
      (WAIT_CYCLES > DMEM_MAX_WAIT)  ? 4'(DMEM_MAX_WAIT - 1) :
                                       4'(WAIT_CYCLES - 1);

   dmem_state_t state_q, state_d;
   dmem_kind_t  kind_q, kind_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic        ok_q, ok_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        rd_ready_q, rd_ready_d;
   logic        wr_ready_q, wr_ready_d;
   logic        err_q, err_d;
   logic        rd_blank_q, rd_blank_d;

   logic                  in_range;
   logic [DEPTH_LOG2-1:0] cur_idx;
   dmem_kind_t            req_kind;
   logic                  go_resp;
   dmem_kind_t            go_kind;
   logic                  go_ok;
   logic [DEPTH_LOG2-1:0] go_idx;

   logic                  ram_re;
   logic                  ram_we;
   logic [31:0]           ram_rdata;
   logic                  unused_addr_lsb;

   assign in_range        = (d_addr[31:TagLsb] == BASE_ADDR[31:TagLsb]);
   assign cur_idx         = d_addr[TagLsb-1:2];
   assign req_kind        = d_wr_req ? WR : RD;
   assign unused_addr_lsb = ^d_addr[1:0];

   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      idx_d      = idx_q;
      ok_d       = ok_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      rd_blank_d = rd_blank_q;
      rd_ready_d = 1'b0;
      wr_ready_d = 1'b0;
      go_resp    = 1'b0;
      go_kind    = kind_q;
      go_ok      = ok_q;
      go_idx     = idx_q;
      ram_re     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (d_wr_req || d_rd_req) begin
               kind_d = req_kind;
               idx_d  = cur_idx;
               ok_d   = in_range;
               if (!in_range) begin
                  err_d = 1'b1;
               end
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
                  go_resp = 1'b1;
                  go_kind = req_kind;
                  go_ok   = in_range;
                  go_idx  = cur_idx;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WaitInit;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
               go_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Read data is captured on the same edge that raises the ready pulse.
      if (go_resp) begin
         rd_ready_d = (go_kind == RD);
         wr_ready_d = (go_kind == WR);
         if (go_kind == RD) begin
            ram_re     = 1'b1;
            rd_blank_d = !go_ok;
         end
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q    <= IDLE;
         kind_q     <= RD;
         idx_q      <= '0;
         ok_q       <= 1'b0;
         cnt_q      <= 4'd0;
         err_q      <= 1'b0;
         rd_blank_q <= 1'b1;
         rd_ready_q <= 1'b0;
         wr_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         kind_q     <= kind_d;
         idx_q      <= idx_d;
         ok_q       <= ok_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         rd_blank_q <= rd_blank_d;
         rd_ready_q <= rd_ready_d;
         wr_ready_q <= wr_ready_d;
      end
   end

   // Store commits on the edge leaving RESP, using the bus values present then.
   assign ram_we = (state_q == RESP) && (kind_q == WR) && ok_q;

   dmem_ram #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk_i   (clk),
      .re_i    (ram_re),
      .raddr_i (go_idx),
      .rdata_o (ram_rdata),
      .we_i    (ram_we),
      .waddr_i (cur_idx),
      .be_i    (d_be),
      .wdata_i (d_wr_data)
   );

   assign d_rd_ready = rd_ready_q;
   assign d_wr_ready = wr_ready_q;
   assign d_rd_data  = rd_blank_q ? 32'h0 : ram_rdata;
   assign err_oob    = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: one instance with no wait states, one with three.
module tb_dmem_resp;

   localparam int W0 = 0;
   localparam int W1 = 3;

   typedef struct {
      logic        wr;
      logic [31:0] data;
   } sb_item_t;

   logic        clk;
   logic        rstb;
   logic [31:0] addr     [2];
   logic        rd_req   [2];
   logic        wr_req   [2];
   logic [3:0]  be       [2];
   logic [31:0] wdata    [2];
   logic        rd_ready [2];
   logic [31:0] rd_data  [2];
   logic        wr_ready [2];
   logic        err      [2];

   sb_item_t sb[$];
   int n_cmp = 0;
   int n_bad = 0;

   dmem_resp #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0001_0000), .WAIT_CYCLES(W0)) u_w0 (
      .clk        (clk),
      .rstb       (rstb),
      .d_addr     (addr[0]),
      .d_rd_req   (rd_req[0]),
      .d_rd_ready (rd_ready[0]),
      .d_rd_data  (rd_data[0]),
      .d_wr_req   (wr_req[0]),
      .d_wr_ready (wr_ready[0]),
      .d_be       (be[0]),
      .d_wr_data  (wdata[0]),
      .err_oob    (err[0])
   );

   dmem_resp #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0001_0000), .WAIT_CYCLES(W1)) u_w3 (
      .clk        (clk),
      .rstb       (rstb),
      .d_addr     (addr[1]),
      .d_rd_req   (rd_req[1]),
      .d_rd_ready (rd_ready[1]),
      .d_rd_data  (rd_data[1]),
      .d_wr_req   (wr_req[1]),
      .d_wr_ready (wr_ready[1]),
      .d_be       (be[1]),
      .d_wr_data  (wdata[1]),
      .err_oob    (err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int d, input logic wr, input logic rd, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] wd);
      addr[d]   = a;
      wr_req[d] = wr;
      rd_req[d] = rd;
      be[d]     = b;
      wdata[d]  = wd;
   endtask

   task automatic expect_xact(input logic wr, input logic [31:0] data);
      sb_item_t it;
      it.wr   = wr;
      it.data = data;
      sb.push_back(it);
   endtask

   // Called just after the edge that opens cycle 0; returns at the negedge of the RESP cycle.
   task automatic wait_ready(input int d, input int exp_lat, input string tag);
      int       n = 0;
      bit       seen = 0;
      sb_item_t it;
      while (!seen && n < 40) begin
         @(negedge clk);
         if (rd_ready[d] || wr_ready[d]) seen = 1;
         else n++;
      end
      if (!seen) begin
         check({tag, " timeout"}, 32'(n), 32'(exp_lat));
      end else begin
         check({tag, " latency"}, 32'(n), 32'(exp_lat));
         check({tag, " both_ready"}, {31'h0, rd_ready[d] & wr_ready[d]}, 32'h0);
         if (sb.size() == 0) begin
            check({tag, " sb_empty"}, 32'h1, 32'h0);
         end else begin
            it = sb.pop_front();
            check({tag, " wr_ready"}, {31'h0, wr_ready[d]}, {31'h0, it.wr});
            check({tag, " rd_ready"}, {31'h0, rd_ready[d]}, {31'h0, !it.wr});
            if (!it.wr) check({tag, " rd_data"}, rd_data[d], it.data);
         end
      end
   endtask

   task automatic do_xact(input int d, input logic wr, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
      @(posedge clk); #1;
      drive(d, wr, !wr, a, b, wd);
      expect_xact(wr, exp_rd);
      wait_ready(d, (d == 0) ? W0 + 1 : W1 + 1, tag);
      @(posedge clk); #1;
      drive(d, 1'b0, 1'b0, a, b, wd);
   endtask

   task automatic check_idle_outputs(input int d, input string tag);
      check({tag, " rd_ready"}, {31'h0, rd_ready[d]}, 32'h0);
      check({tag, " wr_ready"}, {31'h0, wr_ready[d]}, 32'h0);
      check({tag, " rd_data"}, rd_data[d], 32'h0);
      check({tag, " err"}, {31'h0, err[d]}, 32'h0);
   endtask

   initial begin
      rstb = 1'b0;
      for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle_outputs(0, "reset_w0");
      check_idle_outputs(1, "reset_w3");
      rstb = 1'b1;

      // Load latency with no wait states.
      do_xact(0, 1'b1, 32'h0001_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, "w0_preload");
      do_xact(0, 1'b0, 32'h0001_0010, 4'h0, 32'h0, 32'hDEAD_BEEF, "w0_load");

      // Wait states and a single-lane store.
      do_xact(1, 1'b1, 32'h0001_0010, 4'hF, 32'h1122_3344, 32'h0, "w3_preload");
      do_xact(1, 1'b1, 32'h0001_0012, 4'h4, 32'h00AB_0000, 32'h0, "w3_be_store");
      do_xact(1, 1'b0, 32'h0001_0010, 4'h0, 32'h0, 32'h11AB_3344, "w3_be_load");

      // Back-to-back stores with wr_req held high; latency 1 from the IDLE cycle means one gap.
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b0, 32'h0001_0020, 4'hF, 32'hA5A5_A5A5);
      expect_xact(1'b1, 32'h0);
      wait_ready(0, 1, "b2b_first");
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b0, 32'h0001_0024, 4'hF, 32'h5A5A_1234);
      expect_xact(1'b1, 32'h0);
      wait_ready(0, 1, "b2b_second");
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      do_xact(0, 1'b0, 32'h0001_0020, 4'h0, 32'h0, 32'hA5A5_A5A5, "b2b_load0");
      do_xact(0, 1'b0, 32'h0001_0024, 4'h0, 32'h0, 32'h5A5A_1234, "b2b_load1");

      // Out-of-range accesses.
      do_xact(1, 1'b1, 32'h0001_0000, 4'hF, 32'hCAFE_F00D, 32'h0, "oob_preload");
      do_xact(1, 1'b1, 32'h0001_0014, 4'hF, 32'h0BAD_C0DE, 32'h0, "rst_preload");
      check("err_before_oob", {31'h0, err[1]}, 32'h0);
      do_xact(1, 1'b0, 32'h0000_0100, 4'h0, 32'h0, 32'h0, "oob_load");
      check("err_after_oob_load", {31'h0, err[1]}, 32'h1);
      repeat (3) @(posedge clk);
      #1;
      check("err_sticky", {31'h0, err[1]}, 32'h1);
      check("rd_data_held", rd_data[1], 32'h0);
      do_xact(1, 1'b1, 32'h0002_0000, 4'hF, 32'hFFFF_FFFF, 32'h0, "oob_store");
      check("err_after_oob_store", {31'h0, err[1]}, 32'h1);
      do_xact(1, 1'b0, 32'h0001_0000, 4'h0, 32'h0, 32'hCAFE_F00D, "oob_unchanged");

      // Simultaneous requests: write first, then the read sees the new data.
      @(posedge clk); #1;
      drive(1, 1'b1, 1'b1, 32'h0001_0030, 4'hF, 32'h1357_9BDF);
      expect_xact(1'b1, 32'h0);
      expect_xact(1'b0, 32'h1357_9BDF);
      wait_ready(1, W1 + 1, "simul_wr");
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b1, 32'h0001_0030, 4'hF, 32'h1357_9BDF);
      wait_ready(1, W1 + 1, "simul_rd");
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

      // Reset during the WAIT phase of a store.
      @(posedge clk); #1;
      drive(1, 1'b1, 1'b0, 32'h0001_0014, 4'hF, 32'h0000_0000);
      @(negedge clk);
      check("rst_no_ready_c0", {31'h0, wr_ready[1]}, 32'h0);
      @(negedge clk);
      check("rst_no_ready_c1", {31'h0, wr_ready[1]}, 32'h0);
      rstb = 1'b0;
      #1;
      check_idle_outputs(1, "rst_during");
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      @(negedge clk);
      rstb = 1'b1;
      @(negedge clk);
      check_idle_outputs(1, "rst_after");
      do_xact(1, 1'b0, 32'h0001_0014, 4'h0, 32'h0, 32'h0BAD_C0DE, "rst_unchanged");

      check("sb_drained", 32'(sb.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
